// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and the default oversampling
// ratio, common to the receiver and the transmitter.
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial input, sample tick and received-byte outputs.
// The slave modport is taken by the receiver, the master modport by whoever
// drives the line and consumes the bytes.
interface uart_rx_if;

    logic       clk_en;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (
        output clk_en,
        output rx,
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  clk_en,
        input  rx,
        output data,
        output valid,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit. The reset value is a
// parameter so an idle-high line does not look like a start bit out of reset.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops on every clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The line is oversampled by clk_en ticks; the start bit
// is confirmed at its midpoint and every later bit is sampled one full bit
// period after that, i.e. near the middle of each bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_rx_if.slave    bus
);

    localparam int             CW        = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]  HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]  FULL_LAST = CW'(OVERSAMPLE - 1);

    logic          rx_s;
    uart_state_e   state_q,  state_d;
    logic [CW-1:0] tick_q,   tick_d;
    logic [2:0]    bit_q,    bit_d;
    logic [7:0]    shift_q,  shift_d;
    logic [7:0]    data_q,   data_d;
    logic          valid_q,  valid_d;
    logic          ferr_q,   ferr_d;

    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rx),
        .q     (rx_s)
    );

    // Register the FSM state, counters, shift register and output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic; pulses default low so they last exactly one clk.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        if (bus.clk_en) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == HALF_LAST) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == FULL_LAST) begin
                        shift_d = {rx_s, shift_q[7:1]};
                        tick_d  = '0;
                        if (bit_q == 3'd7) begin
                            bit_d   = '0;
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d = '0;
                        if (rx_s) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: clean frames, glitch rejection,
// framing error with break, back-to-back frames, mid-frame reset and a
// divided clk_en.
module tb_uart_rx;

    logic clk = 1'b0;
    logic rst_n;

    int errors = 0;
    int checks = 0;

    int en_div = 1;
    int en_cnt = 0;

    int         valid_count;
    int         ferr_count;
    int         valid_run;
    int         ferr_run;
    int         max_valid_w;
    int         max_ferr_w;
    logic       busy_seen;
    logic       both_seen = 1'b0;
    logic [7:0] cap [4];

    uart_rx_if bus ();

    uart_rx #(
        .OVERSAMPLE (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    // clk_en generator: high every en_div-th clock, changed on the falling edge.
    always @(negedge clk) begin
        en_cnt     = (en_cnt + 1) % en_div;
        bus.clk_en = (en_cnt == 0);
    end

    // Pulse monitor: counts pulses, their widths and captures received bytes.
    always @(negedge clk) begin
        if (bus.valid) begin
            if (valid_count < 4) cap[valid_count] = bus.data;
            valid_count++;
            valid_run++;
            if (valid_run > max_valid_w) max_valid_w = valid_run;
        end else begin
            valid_run = 0;
        end
        if (bus.frame_err) begin
            ferr_count++;
            ferr_run++;
            if (ferr_run > max_ferr_w) max_ferr_w = ferr_run;
        end else begin
            ferr_run = 0;
        end
        if (bus.busy) busy_seen = 1'b1;
        if (bus.valid && bus.frame_err) both_seen = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitClks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearMonitor();
        @(posedge clk);
        valid_count = 0;
        ferr_count  = 0;
        valid_run   = 0;
        ferr_run    = 0;
        max_valid_w = 0;
        max_ferr_w  = 0;
        busy_seen   = 1'b0;
        for (int i = 0; i < 4; i++) cap[i] = 8'hxx;
        @(negedge clk);
    endtask

    task automatic driveBit(input logic v);
        bus.rx = v;
        waitClks(16 * en_div);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(b[i]);
        driveBit(stop_bit);
    endtask

    initial begin
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        waitClks(4);
        checkOutput("rst_data",  bus.data,      8'h00);
        checkOutput("rst_valid", bus.valid,     1'b0);
        checkOutput("rst_ferr",  bus.frame_err, 1'b0);
        checkOutput("rst_busy",  bus.busy,      1'b0);
        rst_n = 1'b1;
        waitClks(20);

        $display("[TB] clean frame 0xA5");
        clearMonitor();
        applyStimulus(8'hA5, 1'b1);
        checkOutput("a5_busy_after", bus.busy, 1'b0);
        waitClks(32);
        checkOutput("a5_valid_cnt", valid_count, 1);
        checkOutput("a5_data",      bus.data,    8'hA5);
        checkOutput("a5_ferr_cnt",  ferr_count,  0);
        checkOutput("a5_valid_w",   max_valid_w, 1);
        checkOutput("a5_busy_seen", busy_seen,   1'b1);

        $display("[TB] short glitch");
        clearMonitor();
        bus.rx = 1'b0;
        waitClks(4);
        bus.rx = 1'b1;
        waitClks(40);
        checkOutput("gl_busy_seen", busy_seen,   1'b1);
        checkOutput("gl_valid_cnt", valid_count, 0);
        checkOutput("gl_ferr_cnt",  ferr_count,  0);
        checkOutput("gl_busy",      bus.busy,    1'b0);
        checkOutput("gl_data",      bus.data,    8'hA5);

        $display("[TB] framing error and break");
        clearMonitor();
        applyStimulus(8'h3C, 1'b0);
        waitClks(40);
        checkOutput("brk_busy_held", bus.busy, 1'b1);
        bus.rx = 1'b1;
        waitClks(32);
        checkOutput("brk_ferr_cnt",  ferr_count,  1);
        checkOutput("brk_ferr_w",    max_ferr_w,  1);
        checkOutput("brk_valid_cnt", valid_count, 0);
        checkOutput("brk_data",      bus.data,    8'hA5);
        checkOutput("brk_busy",      bus.busy,    1'b0);
        clearMonitor();
        applyStimulus(8'h55, 1'b1);
        waitClks(32);
        checkOutput("p55_valid_cnt", valid_count, 1);
        checkOutput("p55_data",      bus.data,    8'h55);
        checkOutput("p55_ferr_cnt",  ferr_count,  0);

        $display("[TB] back-to-back frames");
        clearMonitor();
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        waitClks(32);
        checkOutput("b2b_valid_cnt", valid_count, 2);
        checkOutput("b2b_first",     cap[0],      8'h00);
        checkOutput("b2b_second",    cap[1],      8'hFF);
        checkOutput("b2b_ferr_cnt",  ferr_count,  0);

        $display("[TB] reset during bit 3");
        clearMonitor();
        driveBit(1'b0);
        driveBit(1'b1);
        driveBit(1'b0);
        driveBit(1'b0);
        bus.rx = 1'b0;
        waitClks(8);
        checkOutput("mr_busy_before", bus.busy, 1'b1);
        rst_n  = 1'b0;
        bus.rx = 1'b1;
        waitClks(3);
        checkOutput("mr_rst_data",  bus.data,      8'h00);
        checkOutput("mr_rst_valid", bus.valid,     1'b0);
        checkOutput("mr_rst_ferr",  bus.frame_err, 1'b0);
        checkOutput("mr_rst_busy",  bus.busy,      1'b0);
        rst_n = 1'b1;
        waitClks(48);
        checkOutput("mr_no_valid", valid_count, 0);
        checkOutput("mr_no_ferr",  ferr_count,  0);
        applyStimulus(8'h81, 1'b1);
        waitClks(32);
        checkOutput("mr_valid_cnt", valid_count, 1);
        checkOutput("mr_data",      bus.data,    8'h81);

        $display("[TB] clk_en every 4th clock");
        en_div = 4;
        waitClks(8);
        clearMonitor();
        applyStimulus(8'h5A, 1'b1);
        waitClks(128);
        checkOutput("div_valid_cnt", valid_count, 1);
        checkOutput("div_data",      bus.data,    8'h5A);
        checkOutput("div_valid_w",   max_valid_w, 1);
        checkOutput("div_ferr_cnt",  ferr_count,  0);
        checkOutput("never_both",    both_seen,   1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, number of clk_en ticks per bit period; legal values are 8 or 16.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 clk_en  input  1  sample tick at OVERSAMPLE x baud rate, one clk wide, may be tied high.
REQ-005 rx  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-006 data  output  8  last correctly framed byte; holds value until next valid frame.
REQ-007 valid  output  1  one-clk pulse when data is updated.
REQ-008 frame_err  output  1  one-clk pulse when stop bit sampled low.
REQ-009 busy  output  1  high whenever state is not IDLE.

Function
REQ-010 rx SHALL pass through a 2-FF synchronizer clocked every clk, ungated by clk_en; all decisions use the synchronized value rx_s.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP, BREAK; the FSM advances only on clk cycles with clk_en=1.
REQ-012 IDLE: rx_s=0 -> START with tick counter cleared; else stay.
REQ-013 START: tick counter increments; at tick OVERSAMPLE/2-1, rx_s=0 -> DATA with counter and bit index cleared; rx_s=1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: at tick OVERSAMPLE-1, rx_s SHALL be shifted in at bit 7 of the shift register (shift right), counter cleared, bit index incremented; after bit index 7 -> STOP.
REQ-015 STOP: at tick OVERSAMPLE-1, rx_s=1 -> data loaded from shift register, valid pulsed, -> IDLE; rx_s=0 -> frame_err pulsed, data unchanged, -> BREAK.
REQ-016 BREAK: rx_s=1 -> IDLE; held low indefinitely -> stay; no further pulses.
REQ-017 valid and frame_err SHALL be high exactly one clk cycle, cleared on the next clk edge independent of clk_en; never both high.
REQ-018 Tick counter width SHALL be clog2(OVERSAMPLE); bit index 3 bits; both wrap only through explicit clearing.
REQ-019 A new start edge SHALL be accepted on the first clk_en tick after returning to IDLE (back-to-back frames, no gap required beyond the stop bit).
REQ-020 Illegal state encodings SHALL recover to IDLE on the next clk_en tick.

Reset
REQ-021 While rst_n=0: state IDLE, counters 0, shift register 0, data 8'h00, valid 0, frame_err 0, busy 0, synchronizer FFs 1.
REQ-022 Reset asserted mid-frame SHALL abandon the frame with no valid or frame_err pulse; reception restarts on the next start edge after release.

Structure
REQ-023 State encodings and OVERSAMPLE default SHALL reside in shared package uart_pkg, also usable by uart_tx.
REQ-024 The synchronizer SHALL be a separate sub-module sync_2ff (reset value parameterised, here 1).
REQ-025 No other sub-modules; total RTL within 120-400 lines.

Verification
REQ-026 clk_en tied high, OVERSAMPLE=16, send 0xA5 at 16 clk/bit -> single valid pulse, data=0xA5, frame_err never high, busy low after STOP.
REQ-027 rx low for 4 ticks then high -> busy pulses, returns IDLE, no valid, no frame_err.
REQ-028 Byte 0x3C with stop bit low, rx held low 40 ticks, then byte 0x55 -> one frame_err pulse, data stays at previous value, then valid with data=0x55.
REQ-029 Back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses, data 0x00 then 0xFF.
REQ-030 rst_n pulsed low during bit 3 of 0x81, then full 0x81 sent -> outputs at reset values during reset, no pulse for aborted frame, then valid with data=0x81.
REQ-031 clk_en high every 4th clk, 64 clk/bit, send 0x5A -> valid pulse exactly one clk wide, data=0x5A.
